bnn_stream_loader: RTL and testbench
====================================

// Module: bnn_stream_loader
// PURPOSE
//  Byte-stream front end of the BNN MNIST accelerator; sits directly upstream of the top-level classifier.
//  Deserialises an 8-bit valid/ready stream of typed records into the wide image handshake and the kernel-write port.
//  Supports a binary 28x28 image and weight/offset writes for conv1, conv2 and fc; replaces direct wide-pin loading.
// PARAMETERS
//  bW        8    offset width; 1..8 supported, taken from offset byte [bW-1:0]
//  IMG_W     28   image side; image = IMG_W*IMG_W bits
//  IMG_BYTES 98   derived = ceil(IMG_W*IMG_W/8); not user-set
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, synchronous, active-low
//  in_valid        in   1        stream byte valid
//  in_ready        out  1        loader accepts byte
//  in_data         in   8        stream byte
//  image_in_valid  out  1        image_flat valid to classifier
//  image_in_ready  in   1        classifier accepts image
//  image_flat      out  784      pixel[r][c] = bit r*IMG_W+c
//  kernel_in_valid out  1        one-cycle kernel write strobe
//  kernel_layer    out  2        1=conv1, 2=conv2, 3=fc
//  kernel_addr     out  11       kernel / fc-row index
//  kernel_offset   out  bW       offset value
//  kernel_bits     out  32       conv: [24:0] 5x5 row-major (bit i*5+j); fc: [19:0] weight chunk
//  fc_chunk        out  6        fc chunk index 0..47 (bits chunk*20 +: 20)
//  err_addr        out  1        sticky: out-of-range record dropped; cleared by reset only
// BEHAVIOUR
//  Record = header byte H; H[7:6] type, H[5:0] fc chunk (ignored for other types).
//   type 00 image: H then 98 bytes, byte k bit b -> image bit 8k+b (LSB first); bits 784..  ignored.
//   type 01/10/11: H, addr_lo, addr_hi (addr = {addr_hi[2:0],addr_lo}; addr_hi[7:3] ignored), offset, P0..P3 (kernel_bits = {P3,P2,P1,P0}).
//  Byte accepted only when in_valid & in_ready.
//  FSM: IDLE -> IMG_RX | K_ALO; IMG_RX -(98th byte)-> IMG_OUT -(image_in_valid&image_in_ready)-> IDLE.
//   K_ALO -> K_AHI -> K_OFF -> K_PAY(4 bytes) -> K_WR (1 cycle) -> IDLE.
//  in_ready = 1 in IDLE, IMG_RX, K_ALO, K_AHI, K_OFF, K_PAY; 0 in IMG_OUT and K_WR.
//  image_in_valid rises the cycle after the 98th byte; image_flat stable while valid; drops cycle after handshake.
//  Image shift buffer cleared on entry to IMG_RX; image_flat is the buffer, held after handshake until next image record.
//  kernel_in_valid = 1 only in K_WR, exactly one cycle after P3 accepted; all kernel_* outputs stable that cycle, held otherwise.
//  Range check at K_WR: conv1 addr<=99, conv2 addr<=1199, fc addr<=9 and chunk<=47; failure -> no strobe, err_addr<=1, record consumed.
//  fc chunk range checked against H[5:0]; fc_chunk output = H[5:0].
//  Header type decoded only in IDLE; stream has no resync byte—framing is the sender's responsibility.
//  Reset: state IDLE, in_ready 0 during reset then 1, image_in_valid 0, kernel_in_valid 0, kernel_layer/addr/offset/bits/fc_chunk 0, image_flat 0, err_addr 0.
//  Reset mid-record: partial record discarded, no strobe/valid emitted; next accepted byte is a header.
//  in_valid low mid-record: state and byte counter hold indefinitely.
//  Byte counter 7 bits, wraps only via explicit clear; never exceeds 98.
// TESTING
//  Image 98 bytes 0x55, ready=1 -> valid cycle after byte 98, image_flat bits alternate 1,0 from bit0; valid 1 cycle.
//  Image record, image_in_ready low 10 cycles -> valid held, in_ready=0, image_flat constant; next header accepted after handshake.
//  Conv1 record addr=5 off=0x7F P=0x01FFFFFF -> one strobe, layer=1, addr=5, offset=0x7F, kernel_bits=0x01FFFFFF.
//  Conv1 addr=100 -> no strobe, err_addr=1 sticky; following conv2 addr=1199 record -> strobe layer=2.
//  FC H=0xEF (chunk 47) addr=9 P=0x000FFFFF -> strobe layer=3, fc_chunk=47; H=0xF0 (chunk 48) -> dropped, err_addr=1.
//  Reset after 50 image bytes -> no image_in_valid; fresh conv1 record then strobes normally.

Source files
------------

// File: rtl/bnn_stream_loader.sv
// Byte-stream front end for the BNN MNIST classifier: turns typed 8-bit records
// into the wide image handshake and one-cycle kernel write strobes.
module bnn_stream_loader #(
  parameter int bW    = 8,
  parameter int IMG_W = 28
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  output logic                     image_in_valid,
  input  logic                     image_in_ready,
  output logic [IMG_W*IMG_W-1:0]   image_flat,
  output logic                     kernel_in_valid,
  output logic [1:0]               kernel_layer,
  output logic [10:0]              kernel_addr,
  output logic [bW-1:0]            kernel_offset,
  output logic [31:0]              kernel_bits,
  output logic [5:0]               fc_chunk,
  output logic                     err_addr
);

  localparam int IMG_BITS  = IMG_W * IMG_W;
  localparam int IMG_BYTES = (IMG_BITS + 7) / 8;
  localparam int BUF_BITS  = IMG_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_IMG_RX, ST_IMG_OUT, ST_K_ALO, ST_K_AHI, ST_K_OFF, ST_K_PAY, ST_K_WR
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic [BUF_BITS-1:0] img_q, img_d;
  logic [1:0]          rx_layer_q, rx_layer_d;
  logic [5:0]          rx_chunk_q, rx_chunk_d;
  logic [10:0]         rx_addr_q, rx_addr_d;
  logic [bW-1:0]       rx_off_q, rx_off_d;
  logic [31:0]         rx_bits_q, rx_bits_d;
  logic                k_valid_q, k_valid_d;
  logic [1:0]          k_layer_q, k_layer_d;
  logic [10:0]         k_addr_q, k_addr_d;
  logic [bW-1:0]       k_off_q, k_off_d;
  logic [31:0]         k_bits_q, k_bits_d;
  logic [5:0]          k_chunk_q, k_chunk_d;
  logic                err_q, err_d;
  logic                accept;
  logic                range_ok;

  assign range_ok = (rx_layer_q == 2'd1 && rx_addr_q <= 11'd99)
                 || (rx_layer_q == 2'd2 && rx_addr_q <= 11'd1199)
                 || (rx_layer_q == 2'd3 && rx_addr_q <= 11'd9 && rx_chunk_q <= 6'd47);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    img_d      = img_q;
    rx_layer_d = rx_layer_q;
    rx_chunk_d = rx_chunk_q;
    rx_addr_d  = rx_addr_q;
    rx_off_d   = rx_off_q;
    rx_bits_d  = rx_bits_q;
    k_valid_d  = 1'b0;
    k_layer_d  = k_layer_q;
    k_addr_d   = k_addr_q;
    k_off_d    = k_off_q;
    k_bits_d   = k_bits_q;
    k_chunk_d  = k_chunk_q;
    err_d      = err_q;
    accept     = in_valid & in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_data[7:6] == 2'b00) begin
            state_d = ST_IMG_RX;
            img_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d    = ST_K_ALO;
            rx_layer_d = in_data[7:6];
            rx_chunk_d = in_data[5:0];
          end
        end
      end
      // Right shift lands byte k at bits 8k+7..8k once all bytes are in.
      ST_IMG_RX: begin
        if (accept) begin
          img_d = {in_data, img_q[BUF_BITS-1:8]};
          if (cnt_q == 7'(IMG_BYTES - 1)) begin
            state_d = ST_IMG_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_IMG_OUT: begin
        if (image_in_ready) state_d = ST_IDLE;
      end
      ST_K_ALO: begin
        if (accept) begin
          rx_addr_d[7:0] = in_data;
          state_d        = ST_K_AHI;
        end
      end
      ST_K_AHI: begin
        if (accept) begin
          rx_addr_d[10:8] = in_data[2:0];
          state_d         = ST_K_OFF;
        end
      end
      ST_K_OFF: begin
        if (accept) begin
          rx_off_d = in_data[bW-1:0];
          cnt_d    = '0;
          state_d  = ST_K_PAY;
        end
      end
      // Published kernel_* only change when a legal record completes.
      ST_K_PAY: begin
        if (accept) begin
          rx_bits_d = {in_data, rx_bits_q[31:8]};
          if (cnt_q == 7'd3) begin
            state_d = ST_K_WR;
            cnt_d   = '0;
            if (range_ok) begin
              k_valid_d = 1'b1;
              k_layer_d = rx_layer_q;
              k_addr_d  = rx_addr_q;
              k_off_d   = rx_off_q;
              k_bits_d  = rx_bits_d;
              k_chunk_d = rx_chunk_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      ST_K_WR: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d != ST_IMG_OUT) && (state_d != ST_K_WR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      img_q      <= '0;
      rx_layer_q <= '0;
      rx_chunk_q <= '0;
      rx_addr_q  <= '0;
      rx_off_q   <= '0;
      rx_bits_q  <= '0;
      k_valid_q  <= 1'b0;
      k_layer_q  <= '0;
      k_addr_q   <= '0;
      k_off_q    <= '0;
      k_bits_q   <= '0;
      k_chunk_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      img_q      <= img_d;
      rx_layer_q <= rx_layer_d;
      rx_chunk_q <= rx_chunk_d;
      rx_addr_q  <= rx_addr_d;
      rx_off_q   <= rx_off_d;
      rx_bits_q  <= rx_bits_d;
      k_valid_q  <= k_valid_d;
      k_layer_q  <= k_layer_d;
      k_addr_q   <= k_addr_d;
      k_off_q    <= k_off_d;
      k_bits_q   <= k_bits_d;
      k_chunk_q  <= k_chunk_d;
      err_q      <= err_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign image_in_valid  = (state_q == ST_IMG_OUT);
  assign image_flat      = img_q[IMG_BITS-1:0];
  assign kernel_in_valid = k_valid_q;
  assign kernel_layer    = k_layer_q;
  assign kernel_addr     = k_addr_q;
  assign kernel_offset   = k_off_q;
  assign kernel_bits     = k_bits_q;
  assign fc_chunk        = k_chunk_q;
  assign err_addr        = err_q;

endmodule

// File: tb/tb_bnn_stream_loader.sv
// Self-checking bench for bnn_stream_loader: randomized records checked against
// a record-level model (byte/bit placement and address range rules).
module tb_bnn_stream_loader;

  localparam int BW        = 8;
  localparam int IMG_W     = 28;
  localparam int IMG_BITS  = IMG_W * IMG_W;
  localparam int IMG_BYTES = 98;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [7:0]          in_data = 8'h00;
  logic                image_in_valid;
  logic                image_in_ready = 1'b0;
  logic [IMG_BITS-1:0] image_flat;
  logic                kernel_in_valid;
  logic [1:0]          kernel_layer;
  logic [10:0]         kernel_addr;
  logic [BW-1:0]       kernel_offset;
  logic [31:0]         kernel_bits;
  logic [5:0]          fc_chunk;
  logic                err_addr;

  int errors = 0;
  int checks = 0;

  // Strobe / image-valid monitor state, sampled on the falling edge.
  int            strobes = 0;
  int            img_valid_cycles = 0;
  logic [1:0]    s_layer;
  logic [10:0]   s_addr;
  logic [BW-1:0] s_off;
  logic [31:0]   s_bits;
  logic [5:0]    s_chunk;

  bnn_stream_loader #(.bW(BW), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .image_in_valid(image_in_valid), .image_in_ready(image_in_ready), .image_flat(image_flat),
    .kernel_in_valid(kernel_in_valid), .kernel_layer(kernel_layer), .kernel_addr(kernel_addr),
    .kernel_offset(kernel_offset), .kernel_bits(kernel_bits), .fc_chunk(fc_chunk),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kernel_in_valid) begin
      strobes++;
      s_layer = kernel_layer;
      s_addr  = kernel_addr;
      s_off   = kernel_offset;
      s_bits  = kernel_bits;
      s_chunk = fc_chunk;
    end
    if (image_in_valid) img_valid_cycles++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Record-level rule: which kernel writes are legal.
  function automatic bit model_ok(input logic [1:0] layer, input int addr, input int chunk);
    case (layer)
      2'd1:    return addr < 100;
      2'd2:    return addr < 1200;
      2'd3:    return (addr < 10) && (chunk < 48);
      default: return 1'b0;
    endcase
  endfunction

  // Offer one byte after `gap` idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("[TB] FAIL send_byte_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++;
    if (image_in_valid !== 1'b0 || kernel_in_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valids: img=%0b krn=%0b want 0 0", image_in_valid, kernel_in_valid);
    end
    checks++;
    if ({kernel_layer, kernel_addr, kernel_offset, kernel_bits, fc_chunk} !== '0) begin
      errors++; $display("[TB] FAIL reset_kernel_outs: layer=%0d addr=%0d off=%h bits=%h chunk=%0d want all 0",
                         kernel_layer, kernel_addr, kernel_offset, kernel_bits, fc_chunk);
    end
    checks++;
    if (image_flat !== '0 || err_addr !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_image_err: image_zero=%0b err=%0b want 1 0", image_flat == '0, err_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0b want 1", in_ready); end
  endtask

  // Send one image record (stall = cycles image_in_ready is held low).
  task automatic test_image(input string name, input bit use_55, input int stall);
    logic [7:0]          b [IMG_BYTES];
    logic [IMG_BITS-1:0] exp;
    int                  v0;
    bit                  bad;
    for (int k = 0; k < IMG_BYTES; k++) b[k] = use_55 ? 8'h55 : 8'($urandom);
    for (int i = 0; i < IMG_BITS; i++) exp[i] = b[i / 8][i % 8];
    image_in_ready = (stall == 0);
    v0 = img_valid_cycles;
    send_byte({2'b00, 6'($urandom)}, 0);
    for (int k = 0; k < IMG_BYTES; k++) begin
      send_byte(b[k], 0);
      if (k == IMG_BYTES - 2) begin
        checks++;
        if (image_in_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_early_valid: got %0b want 0", name, image_in_valid); end
      end
    end
    checks++;
    if (image_in_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_valid_rise: got %0b want 1", name, image_in_valid); end
    checks++;
    if (image_flat !== exp) begin errors++; $display("[TB] FAIL %s_image_flat: got low=%h want low=%h", name, image_flat[63:0], exp[63:0]); end
    if (stall > 0) begin
      bad = 1'b0;
      for (int c = 0; c < stall; c++) begin
        @(posedge clk);
        #1;
        if (image_in_valid !== 1'b1 || in_ready !== 1'b0 || image_flat !== exp) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("[TB] FAIL %s_stall_hold: valid=%0b in_ready=%0b want 1 0 stable", name, image_in_valid, in_ready); end
      image_in_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    image_in_ready = 1'b0;
    checks++;
    if (image_in_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s_after_handshake: valid=%0b in_ready=%0b want 0 1", name, image_in_valid, in_ready);
    end
    checks++;
    if (img_valid_cycles - v0 !== stall + 1) begin
      errors++; $display("[TB] FAIL %s_valid_cycles: got %0d want %0d", name, img_valid_cycles - v0, stall + 1);
    end
    checks++;
    if (image_flat !== exp) begin errors++; $display("[TB] FAIL %s_image_held: image changed after handshake", name); end
  endtask

  // Send one kernel record and check strobe, published fields and err_addr.
  task automatic test_kernel_record(input string name, input logic [1:0] layer, input logic [5:0] chunk,
                                    input logic [10:0] addr, input logic [7:0] off,
                                    input logic [31:0] bits, input int maxgap);
    logic [7:0] rec [8];
    logic [4:0] junk;
    int         s0;
    bit         e0;
    bit         ok;
    junk   = 5'($urandom);
    rec[0] = {layer, chunk};
    rec[1] = addr[7:0];
    rec[2] = {junk, addr[10:8]};
    rec[3] = off;
    rec[4] = bits[7:0];
    rec[5] = bits[15:8];
    rec[6] = bits[23:16];
    rec[7] = bits[31:24];
    s0 = strobes;
    e0 = err_addr;
    ok = model_ok(layer, int'(addr), int'(chunk));
    for (int i = 0; i < 8; i++) begin
      send_byte(rec[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i == 6) begin
        checks++;
        if (strobes !== s0) begin errors++; $display("[TB] FAIL %s_early_strobe: got %0d strobes want 0", name, strobes - s0); end
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (strobes - s0 !== (ok ? 1 : 0)) begin
      errors++; $display("[TB] FAIL %s_strobe_count: got %0d want %0d", name, strobes - s0, ok ? 1 : 0);
    end
    if (ok) begin
      checks++;
      if (s_layer !== layer || s_addr !== addr || s_off !== off[BW-1:0] || s_bits !== bits || s_chunk !== chunk) begin
        errors++; $display("[TB] FAIL %s_fields: got L%0d A%0d O%h B%h C%0d want L%0d A%0d O%h B%h C%0d",
                           name, s_layer, s_addr, s_off, s_bits, s_chunk, layer, addr, off[BW-1:0], bits, chunk);
      end
      checks++;
      if (kernel_layer !== layer || kernel_addr !== addr || kernel_bits !== bits || kernel_in_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL %s_held: got L%0d A%0d B%h V%0b want L%0d A%0d B%h V0",
                           name, kernel_layer, kernel_addr, kernel_bits, kernel_in_valid, layer, addr, bits);
      end
    end
    checks++;
    if (err_addr !== (e0 | !ok)) begin errors++; $display("[TB] FAIL %s_err_addr: got %0b want %0b", name, err_addr, e0 | !ok); end
  endtask

  task automatic test_conv1();
    test_kernel_record("conv1_basic", 2'd1, 6'd0, 11'd5, 8'h7F, 32'h01FFFFFF, 0);
  endtask

  task automatic test_range();
    test_kernel_record("conv1_addr100", 2'd1, 6'd3, 11'd100, 8'h12, 32'h00ABCDEF, 0);
    test_kernel_record("conv2_addr1199", 2'd2, 6'd0, 11'd1199, 8'h34, 32'h0155AA55, 0);
    test_kernel_record("conv2_addr1200", 2'd2, 6'd0, 11'd1200, 8'h56, 32'h00000001, 0);
    test_kernel_record("conv1_addr99", 2'd1, 6'd0, 11'd99, 8'h80, 32'h01000000, 0);
  endtask

  task automatic test_fc();
    test_kernel_record("fc_chunk47", 2'd3, 6'd47, 11'd9, 8'hC3, 32'h000FFFFF, 0);
    test_kernel_record("fc_chunk48", 2'd3, 6'd48, 11'd9, 8'h3C, 32'h00012345, 0);
    test_kernel_record("fc_addr10", 2'd3, 6'd0, 11'd10, 8'h01, 32'h000F0F0F, 0);
  endtask

  // Random layers, near-boundary addresses/chunks and random in_valid gaps.
  task automatic test_random();
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [5:0]  chunk;
    for (int n = 0; n < 24; n++) begin
      layer = 2'($urandom_range(1, 3));
      chunk = 6'($urandom_range(40, 63));
      case (layer)
        2'd1:    addr = 11'($urandom_range(90, 110));
        2'd2:    addr = 11'($urandom_range(1190, 1210));
        default: addr = 11'($urandom_range(0, 14));
      endcase
      test_kernel_record("random_kernel", layer, chunk, addr, 8'($urandom), $urandom, 3);
    end
    test_image("random_image", 1'b0, int'($urandom_range(0, 4)));
  endtask

  task automatic test_reset_mid_record();
    int v0;
    int s0;
    v0 = img_valid_cycles;
    s0 = strobes;
    send_byte(8'h00, 0);
    for (int k = 0; k < 50; k++) send_byte(8'($urandom), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || image_flat !== '0 || err_addr !== 1'b0 || kernel_layer !== 2'd0) begin
      errors++; $display("[TB] FAIL midrec_reset_state: in_ready=%0b image_zero=%0b err=%0b layer=%0d want 0 1 0 0",
                         in_ready, image_flat == '0, err_addr, kernel_layer);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (img_valid_cycles !== v0 || strobes !== s0) begin
      errors++; $display("[TB] FAIL midrec_no_output: valid_cycles=%0d strobes=%0d want 0 0", img_valid_cycles - v0, strobes - s0);
    end
    test_kernel_record("midrec_conv1", 2'd1, 6'd0, 11'($urandom_range(0, 99)), 8'($urandom), $urandom, 0);
  endtask

  initial begin
    test_reset();
    test_image("image_55", 1'b1, 0);
    test_image("image_stall", 1'b0, 10);
    test_conv1();
    test_range();
    test_fc();
    test_random();
    test_reset_mid_record();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
